// File: rtl/bch_t3_encoder_lfsr.sv
// Systematic bit-parallel BCH(t=3, GF(2^10)) encoder: message chunks pass through, then 30 parity bits follow.
// Latency: one cycle from an accepted input chunk (or parity load) to out_data; one codeword is (MSG_LEN+PARITY_LEN)/P cycles.
// Backpressure: a held output register (out_valid & ~out_ready) freezes LFSR, counter and state; in_ready drops combinationally.
//
// Ports:
//   clk, in_ctr_Srst (sync active-high reset), in_ctr_en (global enable, low freezes everything)
//   in_valid/in_ready/in_data      : message chunk stream, in_data[P-1] is the highest-degree, earliest bit
//   out_valid/out_ready/out_data   : codeword chunk stream, same bit order
//   out_first/out_last/out_is_parity : first message chunk / last parity chunk / chunk carries parity
module bch_t3_encoder_lfsr #(
    parameter int                  GF_LEN     = 10,
    parameter int                  PARITY_LEN = 30,
    parameter logic [PARITY_LEN:0] GEN_POLY   = 31'h50A9_1113,
    parameter int                  MSG_LEN    = 990,
    parameter int                  P          = 10
) (
    input  logic         clk,
    input  logic         in_ctr_Srst,
    input  logic         in_ctr_en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [P-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [P-1:0] out_data,
    output logic         out_first,
    output logic         out_last,
    output logic         out_is_parity
);

    localparam int MSG_CHUNKS = MSG_LEN / P;
    localparam int PAR_CHUNKS = PARITY_LEN / P;
    localparam int CNT_MAX    = (MSG_CHUNKS > PAR_CHUNKS) ? MSG_CHUNKS : PAR_CHUNKS;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    // Reject configurations the datapath cannot handle.
    generate
        if ((PARITY_LEN % P) != 0 || (MSG_LEN % P) != 0 || PARITY_LEN != 3 * GF_LEN ||
            MSG_LEN > ((1 << GF_LEN) - 1 - PARITY_LEN) || MSG_LEN < P || GEN_POLY[PARITY_LEN] != 1'b1)
        begin : g_bad_cfg
            $error("bch_t3_encoder_lfsr: illegal parameter combination");
        end
    endgenerate

    typedef enum logic {
        ST_MSG    = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PARITY_LEN-1:0]   lfsr_q, lfsr_d;
    logic                    out_valid_q, out_valid_d;
    logic [P-1:0]            out_data_q, out_data_d;
    logic                    out_first_q, out_first_d;
    logic                    out_last_q, out_last_d;
    logic                    out_is_parity_q, out_is_parity_d;

    logic                    adv;
    logic                    fire;
    logic [PARITY_LEN-1:0]   lfsr_msg;
    logic                    fb;

    assign adv       = in_ctr_en & (~out_valid_q | out_ready);
    assign in_ready  = adv & (state_q == ST_MSG);
    assign fire      = in_valid & in_ready;
    assign out_valid = out_valid_q & in_ctr_en;

    assign out_data      = out_data_q;
    assign out_first     = out_first_q;
    assign out_last      = out_last_q;
    assign out_is_parity = out_is_parity_q;

    // P serial division steps unrolled into one cycle, highest-degree bit first.
    always_comb begin
        lfsr_msg = lfsr_q;
        fb       = 1'b0;
        for (int i = P - 1; i >= 0; i--) begin
            fb       = in_data[i] ^ lfsr_msg[PARITY_LEN-1];
            lfsr_msg = {lfsr_msg[PARITY_LEN-2:0], 1'b0} ^ (fb ? GEN_POLY[PARITY_LEN-1:0] : '0);
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        lfsr_d          = lfsr_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_first_d     = out_first_q;
        out_last_d      = out_last_q;
        out_is_parity_d = out_is_parity_q;

        if (adv) begin
            case (state_q)
                ST_MSG: begin
                    if (fire) begin
                        out_valid_d     = 1'b1;
                        out_data_d      = in_data;
                        out_first_d     = (cnt_q == '0);
                        out_last_d      = 1'b0;
                        out_is_parity_d = 1'b0;
                        lfsr_d          = lfsr_msg;
                        if (cnt_q == CNT_W'(MSG_CHUNKS - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_PARITY;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        // Output slot is free but nothing arrived: emit a bubble.
                        out_valid_d = 1'b0;
                    end
                end
                ST_PARITY: begin
                    out_valid_d     = 1'b1;
                    out_data_d      = lfsr_q[PARITY_LEN-1 -: P];
                    out_first_d     = 1'b0;
                    out_last_d      = (cnt_q == CNT_W'(PAR_CHUNKS - 1));
                    out_is_parity_d = 1'b1;
                    // Plain shift: after the final chunk the register is all-zero,
                    // ready for the next codeword without an explicit clear.
                    lfsr_d          = lfsr_q << P;
                    if (cnt_q == CNT_W'(PAR_CHUNKS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_MSG;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_MSG;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_ctr_Srst) begin
            state_q         <= ST_MSG;
            cnt_q           <= '0;
            lfsr_q          <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_first_q     <= 1'b0;
            out_last_q      <= 1'b0;
            out_is_parity_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            lfsr_q          <= lfsr_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_first_q     <= out_first_d;
            out_last_q      <= out_last_d;
            out_is_parity_q <= out_is_parity_d;
        end
    end

endmodule

// File: doc/bch_t3_encoder_lfsr.md
Name: bch_t3_encoder_lfsr

Overview:
- Systematic, bit-parallel BCH encoder for the t=3 code over GF(2^10). It is the transmit-side counterpart of the t=3 syndrome/error-locator decode chain.
- Message chunks stream through unchanged; the block then appends the 30-bit parity remainder of m(x)·x^30 mod g(x).
- The streaming interface is valid/ready on both sides, with a single output register stage.
- Codewords produced by this block must decode with all-zero syndromes S1, S3, S5.

Parameters:
- GF_LEN, 10, field degree m.
- PARITY_LEN, 30, parity bits (GF_LEN*3). Equals the degree of g(x).
- GEN_POLY, 31-bit, generator g(x) = M1·M3·M5 for field polynomial x^10+x^3+1. Bit i is the coefficient of x^i; bit 30 must be 1.
- MSG_LEN, 990, message bits per codeword. Must be ≤993 and a multiple of P.
- P, 10, bits per cycle. Must divide PARITY_LEN and MSG_LEN. Elaboration fails otherwise.

Ports:
- clk  in  1  clock
- in_ctr_Srst  in  1  synchronous reset, active-high
- in_ctr_en  in  1  global enable. Low freezes all state.
- in_valid  in  1  message chunk valid
- in_ready  out  1  block accepts chunk
- in_data  in  P  message chunk. Bit P-1 is the highest-degree coefficient and is earliest in time.
- out_valid  out  1  output chunk valid
- out_ready  in  1  downstream accepts chunk
- out_data  out  P  codeword chunk, same bit order as in_data
- out_first  out  1  chunk is first of codeword
- out_last  out  1  chunk is last parity chunk
- out_is_parity  out  1  chunk is parity

Behaviour:

Reset:
- in_ctr_Srst=1 at a clk edge clears the LFSR (PARITY_LEN bits), the chunk counter and all output registers. State goes to MSG.
- Outputs after reset: out_valid=0, out_data=0, out_first=0, out_last=0, out_is_parity=0.
- Reset wins over in_ctr_en and over any handshake. A reset mid-codeword aborts it; no partial parity is emitted.

Core handshake:
- adv = in_ctr_en & (~out_valid_q | out_ready).
- out_valid = out_valid_q & in_ctr_en. A transfer occurs only when out_valid & out_ready.
- in_ready = adv & (state==MSG). This is combinational from out_ready.

State MSG:
- On fire (in_valid & in_ready), load the output register with in_data and set out_is_parity=0.
- out_first=1 iff the chunk count is 0.
- Update the LFSR by P serial steps in one cycle, MSB first: fb = in_bit ^ lfsr[29]; lfsr = (lfsr<<1) ^ (fb ? GEN_POLY[29:0] : 0).
- Increment the counter.
- On the fire of chunk MSG_LEN/P-1: counter→0, state→PARITY.
- If adv=1 but there is no fire, set out_valid_q←0 (bubble).

State PARITY:
- On each adv, load the output register with lfsr[29:29-P+1], set out_is_parity=1, and shift the LFSR left by P with zero fill (no feedback).
- out_last=1 on chunk PARITY_LEN/P-1. On that edge, state→MSG and counter→0.
- The LFSR is all-zero after the final shift; no explicit clear is needed.

Latency and throughput:
- An accepted input chunk appears on out_data the next cycle.
- The first parity chunk is loaded on the first adv after the last message fire.
- With out_ready=1 and in_valid=1, a codeword takes exactly (MSG_LEN+PARITY_LEN)/P cycles. Back-to-back codewords have no bubble; the default is 102 cycles.

Backpressure:
- With out_ready=0 and out_valid_q=1, the output register, LFSR, counter and state hold.
- in_ready=0 in this condition. out_data is stable until accepted.

Enable:
- in_ctr_en=0 freezes all registers. in_ready=0 and out_valid=0; the registered content is retained.

Parity:
- Parity bit order: r29 is emitted first.
- Codeword is c(x) = m(x)·x^30 + r(x).

Test Plan:
- All-zero message, P=10, MSG_LEN=990, out_ready=1 → 99 zero message chunks, then 3 zero parity chunks. out_first on cycle 1 after the first fire; out_last on the 102nd output chunk.
- Message with only the last bit =1 (final chunk 10'h001) → parity chunks GEN_POLY[29:20], [19:10], [9:0].
- 200 random messages → parity matches the bench polynomial-division model. Syndromes S1, S3, S5 computed by the existing GF(2^10) multiplier model are 0. Flipping 1–3 codeword bits yields a locator whose roots identify the flipped positions.
- Random out_ready (50%) and random in_valid gaps → output sequence identical to the no-stall run. out_data is never changed while out_valid & ~out_ready. in_ready=0 throughout PARITY.
- Pulse in_ctr_en=0 for 5 cycles mid-message and again mid-parity → same codeword as the no-pulse run. out_valid=0 and in_ready=0 during the pulses.
- Assert in_ctr_Srst at message chunk 40 and again during parity chunk 1 → next cycle all outputs are 0. A fresh codeword then encodes correctly, matching the single-bit-message result.
